vid_tx: RTL and testbench
=========================

VID_TX -- requirements
Module: vid_tx

Interface
- REQ-001 The block SHALL have the following parameters (name, default, meaning):
  - H_ACTIVE 640: active pixels per line
  - H_FP 16: horizontal front porch
  - H_SYNC 96: hsync width
  - H_BP 48: horizontal back porch
  - V_ACTIVE 480: active lines
  - V_FP 10: vertical front porch
  - V_SYNC 2: vsync width
  - V_BP 33: vertical back porch
  - SYNC_POL 1: asserted level of hsync/vsync
  - FIFO_DEPTH 16: pixel FIFO entries, power of two, at least 4
  - BLANK 24'h000000: data driven outside active video and on underflow
- REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  - clk, in, 1: the only clock
  - rst, in, 1: reset, synchronous, active-high
  - s_data, in, 24: pixel {red, grn, blu}
  - s_sof, in, 1: start of frame; marks the first pixel of a frame
  - s_vld, in, 1: input pixel valid
  - s_rdy, out, 1: input ready
  - data_o, out, 24: output pixel
  - vde_o, out, 1: video data enable
  - hsync_o, out, 1: horizontal sync
  - vsync_o, out, 1: vertical sync
  - locked_o, out, 1: in STREAM state
  - underflow_o, out, 1: sticky underflow/resync error

Function
- REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - hcnt SHALL count 0..H_TOTAL-1 and wrap to 0.
  - vcnt SHALL increment when hcnt wraps, count 0..V_TOTAL-1 and wrap to 0.
- REQ-004 Timing decode, on counter values:
  - act = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
  - hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- REQ-005 All outputs SHALL be registered with latency 1: the outputs in cycle n reflect the counters and FIFO head of cycle n-1.
  - vde_o = act.
  - hsync_o = hs ? SYNC_POL : !SYNC_POL; vsync_o uses the same rule with vs.
- REQ-006 Counters SHALL free-run regardless of input; timing never stalls.
- REQ-007 Pixel FIFO:
  - Holds {sof, data}, FIFO_DEPTH entries.
  - s_rdy = !full; a push occurs when s_vld && s_rdy.
  - A push and a pop in the same cycle SHALL both succeed, including when full (s_rdy stays low while full) and when empty (a push into an empty FIFO is not poppable until the next cycle).
- REQ-008 The output state machine SHALL have states IDLE and STREAM.
- REQ-009 In IDLE:
  - data_o = BLANK whenever vde_o is high.
  - Any head entry with sof=0 SHALL be popped and discarded, one per cycle.
  - A head entry with sof=1 SHALL be held.
- REQ-010 IDLE to STREAM SHALL occur in the cycle where hcnt=0, vcnt=0, the FIFO is non-empty and the head has sof=1.
  - That head SHALL be popped in that cycle and output as the first pixel.
- REQ-011 In STREAM, each cycle with act=1 SHALL pop one entry and drive its data on data_o in the next cycle.
  - With act=0, nothing is popped.
- REQ-012 Underflow: in STREAM with act=1 and the FIFO empty:
  - data_o = BLANK.
  - underflow_o SHALL be set.
  - The state SHALL return to IDLE.
- REQ-013 Unexpected SOF: in STREAM, a head with sof=1 while act=1 and (hcnt,vcnt)≠(0,0):
  - underflow_o SHALL be set and the state SHALL return to IDLE.
  - That entry SHALL NOT be popped, so it is available for the next frame start.
- REQ-014 data_o SHALL be BLANK whenever vde_o is low.
- REQ-015 underflow_o SHALL be sticky and clear only on rst.
- REQ-016 locked_o = (state==STREAM), registered with the other outputs.

Reset
- REQ-017 While rst is high, on each clk edge:
  - hcnt=0, vcnt=0, FIFO emptied, state=IDLE.
  - data_o=BLANK, vde_o=0, hsync_o=vsync_o=!SYNC_POL.
  - locked_o=0, underflow_o=0, s_rdy=0.
- REQ-018 The first cycle after rst deasserts SHALL count hcnt=0, vcnt=0.
  - s_rdy SHALL go high in that cycle.
- REQ-019 rst asserted mid-frame SHALL discard all FIFO contents and restart timing at (0,0) on the next edge.

Verification
Parameters for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); FIFO_DEPTH=4.
- REQ-020 Timing only, no input:
  - vde_o high for 4 cycles in each of 3 lines per 48-cycle frame.
  - hsync_o high for output cycles 6..7 of each line.
  - vsync_o high for line 4.
  - data_o=BLANK throughout.
- REQ-021 Full frame: push 12 pixels 0x000001..0x00000C with sof on the first, always valid.
  - locked_o=1; active outputs are 1..12 in order; underflow_o=0.
- REQ-022 Leading garbage: push 3 pixels with sof=0, then a valid frame.
  - The garbage is discarded; the frame starts at (0,0) with the sof pixel.
- REQ-023 Starvation: supply only 5 pixels of a frame.
  - The 6th active output is BLANK; underflow_o=1; locked_o=0 next cycle.
  - The next full frame locks correctly.
- REQ-024 Backpressure: s_vld held high before lock.
  - s_rdy drops after 4 accepted entries and rises in the first cycle after a pop.
- REQ-025 Reset mid-line at hcnt=2, vcnt=1 with FIFO non-empty:
  - After release, outputs restart from (0,0), the FIFO is empty, underflow_o=0.

Source files
------------

// File: rtl/vid_tx.sv
// Video timing generator with a pixel FIFO; locks the incoming stream to the
// raster at (0,0) on an SOF pixel and falls back to IDLE on underflow or a stray SOF.
module vid_tx #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          SYNC_POL   = 1'b1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [23:0] BLANK      = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        s_vld,
    output logic        s_rdy,
    output logic [23:0] data_o,
    output logic        vde_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        locked_o,
    output logic        underflow_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so the sync end bound never wraps when the back porch is zero.
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          act, hs, vs, at_origin;

    logic [24:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic          head_sof;
    logic [23:0]   head_data;

    state_e        state_q, state_d;
    logic [23:0]   pix;
    logic          uf_set;

    // Raster counters free-run; nothing downstream can stall them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    assign act       = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs        = (hcnt >= HS_START) && (hcnt < HS_END);
    assign vs        = (vcnt >= VS_START) && (vcnt < VS_END);
    assign at_origin = (hcnt == '0) && (vcnt == '0);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign s_rdy = !rst && !full;
    assign push  = s_vld && s_rdy;

    assign head_sof  = mem[rd_ptr][24];
    assign head_data = mem[rd_ptr][23:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_sof, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        pix     = BLANK;
        uf_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (!head_sof) begin
                        pop = 1'b1;
                    end else if (at_origin) begin
                        pop     = 1'b1;
                        pix     = head_data;
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (act) begin
                    if (empty || (head_sof && !at_origin)) begin
                        // Stray SOF stays queued so it can start the next frame.
                        uf_set  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        pop = 1'b1;
                        pix = head_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            data_o      <= BLANK;
            vde_o       <= 1'b0;
            hsync_o     <= !SYNC_POL;
            vsync_o     <= !SYNC_POL;
            locked_o    <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_o      <= act ? pix : BLANK;
            vde_o       <= act;
            hsync_o     <= hs ? SYNC_POL : !SYNC_POL;
            vsync_o     <= vs ? SYNC_POL : !SYNC_POL;
            locked_o    <= (state_q == StStream);
            underflow_o <= underflow_o | uf_set;
        end
    end

endmodule

// File: tb/tb_vid_tx.sv
// Scoreboard bench for vid_tx on an 8x6 raster with a 4-entry FIFO.
module tb_vid_tx;

    localparam logic [23:0] BLANK = 24'h000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_vld = 1'b0;
    logic        s_rdy;
    logic [23:0] data_o;
    logic        vde_o, hsync_o, vsync_o, locked_o, underflow_o;

    vid_tx #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .FIFO_DEPTH(4), .BLANK(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_sof(s_sof), .s_vld(s_vld),
        .s_rdy(s_rdy), .data_o(data_o), .vde_o(vde_o), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .locked_o(locked_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          frame;
        logic [23:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rst_last = 1'b1;

    // cyc == n during raster cycle n (counters of the DUT at hcnt/vcnt for cycle n).
    always @(posedge clk) begin
        rst_last <= rst;
        cyc      <= rst ? 0 : cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic expect_frame(input int frame, input logic [23:0] base, input int n);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            e.frame = frame;
            e.data  = base + 24'(i);
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < n && g < 3000);
        if (cyc < n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc timeout got=%0d want=%0d", cyc, n);
        end
    endtask

    task automatic send(input logic [23:0] d, input logic sof);
        int g;
        g = 0;
        @(negedge clk);
        s_data = d;
        s_sof  = sof;
        s_vld  = 1'b1;
        while (!s_rdy && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!s_rdy) begin
            checks++;
            errors++;
            $display("FAIL send timeout got=s_rdy_low want=accept data=%h", d);
            s_vld = 1'b0;
        end else begin
            @(posedge clk);
            #1 s_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: raster timing from the bench's own cycle count, pixels from the scoreboard.
    initial begin
        int   m, h, v, f;
        bit   e_vde, e_hs, e_vs;
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_last) begin
                check("rst_data", data_o, BLANK);
                check("rst_vde", vde_o, 0);
                check("rst_hsync", hsync_o, 0);
                check("rst_vsync", vsync_o, 0);
                check("rst_locked", locked_o, 0);
                check("rst_underflow", underflow_o, 0);
                if (rst) check("rst_s_rdy", s_rdy, 0);
            end else if (cyc >= 1) begin
                m     = cyc - 1;
                h     = m % 8;
                v     = (m / 8) % 6;
                f     = m / 48;
                e_vde = (h < 4) && (v < 3);
                e_hs  = (h >= 5) && (h < 7);
                e_vs  = (v == 4);
                check("vde", vde_o, e_vde);
                check("hsync", hsync_o, e_hs);
                check("vsync", vsync_o, e_vs);
                if (e_vde && sb.size() > 0 && sb[0].frame == f) begin
                    e = sb.pop_front();
                    check("pixel", data_o, e.data);
                end else begin
                    check("blank", data_o, BLANK);
                end
            end
        end
    end

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Timing-only frame 0, then a full frame locked at frame 2 with backpressure.
        wait_cyc(2);
        check("idle_locked", locked_o, 0);
        check("idle_underflow", underflow_o, 0);
        expect_frame(2, 24'h000000, 12);
        wait_cyc(50);
        for (int i = 1; i <= 4; i++) send(24'(i), i == 1);
        @(negedge clk);
        check("bp_rdy_low", s_rdy, 0);
        g = 0;
        while (!s_rdy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("bp_rdy_rise_cyc", cyc, 97);
        for (int i = 5; i <= 12; i++) send(24'(i), 1'b0);
        wait_cyc(100);
        check("full_locked", locked_o, 1);
        wait_cyc(140);
        check("full_locked_end", locked_o, 1);
        check("full_underflow", underflow_o, 0);
        do_reset();

        // Leading garbage is dropped; frame locks at frame 1.
        expect_frame(1, 24'h0A0000, 12);
        wait_cyc(10);
        for (int i = 1; i <= 3; i++) send(24'hBAD000 + 24'(i), 1'b0);
        for (int i = 1; i <= 12; i++) send(24'h0A0000 + 24'(i), i == 1);
        wait_cyc(95);
        check("garb_locked", locked_o, 1);
        check("garb_underflow", underflow_o, 0);
        do_reset();

        // Starvation after 5 pixels, then recovery on the next frame.
        expect_frame(1, 24'h0C0000, 5);
        sb.push_back('{frame: 1, data: BLANK});
        wait_cyc(10);
        for (int i = 1; i <= 5; i++) send(24'h0C0000 + 24'(i), i == 1);
        wait_cyc(57);
        check("starve_uf_before", underflow_o, 0);
        check("starve_locked_before", locked_o, 1);
        wait_cyc(58);
        check("starve_uf_set", underflow_o, 1);
        check("starve_locked_still", locked_o, 1);
        wait_cyc(59);
        check("starve_unlocked", locked_o, 0);
        check("starve_uf_sticky", underflow_o, 1);
        expect_frame(2, 24'h0D0000, 12);
        for (int i = 1; i <= 12; i++) send(24'h0D0000 + 24'(i), i == 1);
        wait_cyc(100);
        check("relock", locked_o, 1);
        wait_cyc(140);
        check("relock_end", locked_o, 1);
        check("relock_uf_sticky", underflow_o, 1);
        do_reset();

        // Reset mid-line at hcnt=2, vcnt=1 with a queued frame start.
        wait_cyc(1);
        for (int i = 1; i <= 4; i++) send(24'h0E0000 + 24'(i), i == 1);
        wait_cyc(8);
        check("midrst_full", s_rdy, 0);
        wait_cyc(10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_cyc0", cyc, 0);
        check("midrst_s_rdy", s_rdy, 1);
        wait_cyc(2);
        check("midrst_locked", locked_o, 0);
        wait_cyc(60);
        check("midrst_locked_end", locked_o, 0);
        check("midrst_underflow", underflow_o, 0);
        check("sb_final", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
